// File: rtl/epb_bus_sync.sv
// epb_bus_sync: clocked EPB slave front-end. Synchronises the EPB chip-select,
// captures the request, hands a one-cycle strobe to fabric and returns ready.
// Optional macro EPB_BUS_SYNC_TIMEOUT_EN: forced completion after TIMEOUT cycles.
// Ports:
//   sys_clk, sys_rst_n            clock, async active-low reset
//   epb_cs_n/r_w_n/be_n/addr/..   EPB side inputs (cs_n asynchronous)
//   epb_data_out/oe_n/rdy         EPB side registered outputs
//   fab_req/rnw/addr/addr_gp/be   fabric request and captured fields
//   fab_wr_data, fab_rd_data      fabric write / read data
//   fab_ack                       fabric completion
//   epb_err                       one-cycle pulse on timeout or abort
module epb_bus_sync #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 23,
    parameter int GP_W        = 6,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic                epb_cs_n,
    input  logic                epb_r_w_n,
    input  logic [DATA_W/8-1:0] epb_be_n,
    input  logic [ADDR_W-1:0]   epb_addr,
    input  logic [GP_W-1:0]     epb_addr_gp,
    input  logic [DATA_W-1:0]   epb_data_in,
    output logic [DATA_W-1:0]   epb_data_out,
    output logic                epb_data_oe_n,
    output logic                epb_rdy,
    output logic                fab_req,
    output logic                fab_rnw,
    output logic [ADDR_W-1:0]   fab_addr,
    output logic [GP_W-1:0]     fab_addr_gp,
    output logic [DATA_W/8-1:0] fab_be,
    output logic [DATA_W-1:0]   fab_wr_data,
    input  logic [DATA_W-1:0]   fab_rd_data,
    input  logic                fab_ack,
    output logic                epb_err
);

    localparam int BE_W = DATA_W / 8;
    // The last synchroniser stage is merged into the FSM/output registers:
    // they update on the same edge that cs_s would take its new value.
    localparam int SW = SYNC_STAGES - 1;

    if ((DATA_W % 8) != 0 || DATA_W < 8) begin : g_chk_dw
        $error("DATA_W must be a non-zero multiple of 8");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_chk_ss
        $error("SYNC_STAGES must be 2..4");
    end
    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_chk_to
        $error("TIMEOUT must be 1..65535");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP
    } state_e;

    state_e state_q, state_d;

    logic [SW-1:0]     sync_q;
    logic [1:0]        fill_q;
    logic              fill_full;
    logic              cs_nxt;
    logic              armed_q, armed_d;
    logic              cap;
    logic              tmo_hit;

    logic              req_d, err_d, rdy_d, oe_n_d;
    logic [DATA_W-1:0] rd_d;

    logic              fab_req_q, fab_rnw_q, epb_err_q, epb_rdy_q, oe_n_q;
    logic [ADDR_W-1:0] fab_addr_q;
    logic [GP_W-1:0]   fab_gp_q;
    logic [BE_W-1:0]   fab_be_q;
    logic [DATA_W-1:0] fab_wr_q;
    logic [DATA_W-1:0] rd_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q[0] <= epb_cs_n;
            for (int i = 1; i < SW; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // The chain comes out of reset full of ones that were never sampled;
    // only real samples may arm the slave, so a transfer already in
    // progress at reset release is ignored until cs has truly been high.
    assign cs_nxt    = sync_q[SW-1];
    assign fill_full = (fill_q == 2'(SW));
    assign armed_d   = armed_q | (fill_full & cs_nxt);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            fill_q  <= '0;
            armed_q <= 1'b0;
        end else begin
            if (!fill_full) begin
                fill_q <= fill_q + 2'd1;
            end
            armed_q <= armed_d;
        end
    end

`ifdef EPB_BUS_SYNC_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    logic [15:0] tmo_q, tmo_d;

    assign tmo_d   = (state_q == S_WAIT) ? tmo_q + 16'd1 : 16'd0;
    assign tmo_hit = (tmo_q == TMO_LAST);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cap     = 1'b0;
        req_d   = 1'b0;
        err_d   = 1'b0;
        rd_d    = rd_q;
        case (state_q)
            S_IDLE: begin
                if (armed_q && fill_full && !cs_nxt) begin
                    state_d = S_REQ;
                    cap     = 1'b1;
                    req_d   = 1'b1;
                end
            end
            S_REQ: begin
                if (fab_ack) begin
                    state_d = S_RESP;
                    rd_d    = fab_rd_data;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (fab_ack) begin
                    state_d = S_RESP;
                    rd_d    = fab_rd_data;
                end else if (cs_nxt) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else if (tmo_hit) begin
                    state_d = S_RESP;
                    rd_d    = '1;
                    err_d   = 1'b1;
                end
            end
            S_RESP: begin
                if (cs_nxt) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign rdy_d  = (state_d == S_RESP);
    assign oe_n_d = !((state_d == S_RESP) && fab_rnw_q);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= S_IDLE;
            fab_req_q  <= 1'b0;
            fab_rnw_q  <= 1'b1;
            fab_addr_q <= '0;
            fab_gp_q   <= '0;
            fab_be_q   <= '0;
            fab_wr_q   <= '0;
            rd_q       <= '0;
            epb_err_q  <= 1'b0;
            epb_rdy_q  <= 1'b0;
            oe_n_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            fab_req_q <= req_d;
            epb_err_q <= err_d;
            epb_rdy_q <= rdy_d;
            oe_n_q    <= oe_n_d;
            rd_q      <= rd_d;
            if (cap) begin
                fab_rnw_q  <= epb_r_w_n;
                fab_addr_q <= epb_addr;
                fab_gp_q   <= epb_addr_gp;
                fab_be_q   <= ~epb_be_n;
                fab_wr_q   <= epb_data_in;
            end
        end
    end

    assign epb_data_out  = rd_q;
    assign epb_data_oe_n = oe_n_q;
    assign epb_rdy       = epb_rdy_q;
    assign epb_err       = epb_err_q;
    assign fab_req       = fab_req_q;
    assign fab_rnw       = fab_rnw_q;
    assign fab_addr      = fab_addr_q;
    assign fab_addr_gp   = fab_gp_q;
    assign fab_be        = fab_be_q;
    assign fab_wr_data   = fab_wr_q;

endmodule

// File: tb/tb_epb_bus_sync.sv
// tb_epb_bus_sync: directed self-checking bench for epb_bus_sync.
// Drives EPB and fabric sides on negedge, samples outputs on negedge.
module tb_epb_bus_sync;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        epb_cs_n;
    logic        epb_r_w_n;
    logic [1:0]  epb_be_n;
    logic [22:0] epb_addr;
    logic [5:0]  epb_addr_gp;
    logic [15:0] epb_data_in;
    logic [15:0] epb_data_out;
    logic        epb_data_oe_n;
    logic        epb_rdy;
    logic        fab_req;
    logic        fab_rnw;
    logic [22:0] fab_addr;
    logic [5:0]  fab_addr_gp;
    logic [1:0]  fab_be;
    logic [15:0] fab_wr_data;
    logic [15:0] fab_rd_data;
    logic        fab_ack;
    logic        epb_err;

    int n_chk  = 0;
    int n_fail = 0;
    int req_cnt = 0;
    int oe_low  = 0;
    int rdy_cnt = 0;
    int err_cnt = 0;

    epb_bus_sync #(
        .DATA_W(16), .ADDR_W(23), .GP_W(6), .SYNC_STAGES(2), .TIMEOUT(4)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst_n(sys_rst_n),
        .epb_cs_n(epb_cs_n),
        .epb_r_w_n(epb_r_w_n),
        .epb_be_n(epb_be_n),
        .epb_addr(epb_addr),
        .epb_addr_gp(epb_addr_gp),
        .epb_data_in(epb_data_in),
        .epb_data_out(epb_data_out),
        .epb_data_oe_n(epb_data_oe_n),
        .epb_rdy(epb_rdy),
        .fab_req(fab_req),
        .fab_rnw(fab_rnw),
        .fab_addr(fab_addr),
        .fab_addr_gp(fab_addr_gp),
        .fab_be(fab_be),
        .fab_wr_data(fab_wr_data),
        .fab_rd_data(fab_rd_data),
        .fab_ack(fab_ack),
        .epb_err(epb_err)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    always @(negedge sys_clk) begin
        if (fab_req) req_cnt++;
        if (!epb_data_oe_n) oe_low++;
        if (epb_rdy) rdy_cnt++;
        if (epb_err) err_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge sys_clk);
    endtask

    task automatic start(input logic [22:0] a, input logic rnw,
                         input logic [1:0] ben, input logic [15:0] din);
        epb_addr    = a;
        epb_addr_gp = a[5:0];
        epb_r_w_n   = rnw;
        epb_be_n    = ben;
        epb_data_in = din;
        epb_cs_n    = 1'b0;
    endtask

    task automatic wait_req(output int n);
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge sys_clk);
            if (fab_req) begin
                n = i;
                break;
            end
        end
    endtask

    int lat;
    int r0, o0, e0, d0;

    initial begin
        sys_rst_n   = 1'b0;
        epb_cs_n    = 1'b1;
        epb_r_w_n   = 1'b1;
        epb_be_n    = 2'b11;
        epb_addr    = '0;
        epb_addr_gp = '0;
        epb_data_in = '0;
        fab_rd_data = '0;
        fab_ack     = 1'b0;
        tick(3);
        chk("rst_dout", 32'(epb_data_out), 32'h0);
        chk("rst_oe_n", 32'(epb_data_oe_n), 32'h1);
        chk("rst_rdy", 32'(epb_rdy), 32'h0);
        chk("rst_req", 32'(fab_req), 32'h0);
        chk("rst_rnw", 32'(fab_rnw), 32'h1);
        chk("rst_addr", 32'(fab_addr), 32'h0);
        chk("rst_be", 32'(fab_be), 32'h0);
        chk("rst_wr", 32'(fab_wr_data), 32'h0);
        chk("rst_err", 32'(epb_err), 32'h0);
        sys_rst_n = 1'b1;
        tick(4);

        // read with ack three cycles after the request
        r0 = req_cnt;
        start(23'h000123, 1'b1, 2'b00, 16'h0);
        wait_req(lat);
        chk("rd_lat", 32'(lat), 32'd2);
        chk("rd_addr", 32'(fab_addr), 32'h000123);
        chk("rd_be", 32'(fab_be), 32'h3);
        chk("rd_rnw", 32'(fab_rnw), 32'h1);
        tick(1);
        chk("rd_req_1cyc", 32'(fab_req), 32'h0);
        tick(1);
        chk("rd_rdy_pre", 32'(epb_rdy), 32'h0);
        fab_ack     = 1'b1;
        fab_rd_data = 16'hBEEF;
        tick(1);
        fab_ack     = 1'b0;
        fab_rd_data = 16'h0;
        chk("rd_rdy", 32'(epb_rdy), 32'h1);
        chk("rd_oe_n", 32'(epb_data_oe_n), 32'h0);
        chk("rd_dout", 32'(epb_data_out), 32'hBEEF);
        epb_cs_n = 1'b1;
        tick(1);
        chk("rd_rdy_hold", 32'(epb_rdy), 32'h1);
        tick(1);
        chk("rd_rdy_rel", 32'(epb_rdy), 32'h0);
        chk("rd_oe_rel", 32'(epb_data_oe_n), 32'h1);
        chk("rd_nreq", 32'(req_cnt - r0), 32'd1);
        tick(2);

        // write
        r0 = req_cnt;
        o0 = oe_low;
        start(23'h000456, 1'b0, 2'b10, 16'h5A5A);
        wait_req(lat);
        chk("wr_lat", 32'(lat), 32'd2);
        chk("wr_data", 32'(fab_wr_data), 32'h5A5A);
        chk("wr_be", 32'(fab_be), 32'h1);
        chk("wr_rnw", 32'(fab_rnw), 32'h0);
        tick(1);
        fab_ack = 1'b1;
        tick(1);
        fab_ack = 1'b0;
        chk("wr_rdy", 32'(epb_rdy), 32'h1);
        chk("wr_oe_n", 32'(epb_data_oe_n), 32'h1);
        tick(3);
        chk("wr_cs_hold", 32'(epb_rdy), 32'h1);
        epb_cs_n = 1'b1;
        tick(3);
        chk("wr_rdy_rel", 32'(epb_rdy), 32'h0);
        chk("wr_oe_never", 32'(oe_low - o0), 32'd0);
        chk("wr_nreq", 32'(req_cnt - r0), 32'd1);

        // spurious ack while idle
        r0 = req_cnt;
        fab_ack = 1'b1;
        tick(3);
        chk("idle_ack_rdy", 32'(epb_rdy), 32'h0);
        chk("idle_ack_req", 32'(req_cnt - r0), 32'd0);
        fab_ack = 1'b0;
        tick(2);

        // ack in the same cycle as the request
        start(23'h000007, 1'b1, 2'b01, 16'h0);
        wait_req(lat);
        chk("req_ack_lat", 32'(lat), 32'd2);
        fab_ack     = 1'b1;
        fab_rd_data = 16'h1234;
        tick(1);
        fab_ack = 1'b0;
        chk("req_ack_rdy", 32'(epb_rdy), 32'h1);
        chk("req_ack_dout", 32'(epb_data_out), 32'h1234);
        epb_cs_n = 1'b1;
        tick(4);

        // no ack: forced completion or indefinite wait
        e0 = err_cnt;
        d0 = rdy_cnt;
        start(23'h000009, 1'b1, 2'b00, 16'h0);
        wait_req(lat);
`ifdef EPB_BUS_SYNC_TIMEOUT_EN
        tick(4);
        chk("tmo_rdy_pre", 32'(epb_rdy), 32'h0);
        tick(1);
        chk("tmo_rdy", 32'(epb_rdy), 32'h1);
        chk("tmo_err", 32'(epb_err), 32'h1);
        chk("tmo_dout", 32'(epb_data_out), 32'hFFFF);
        tick(1);
        chk("tmo_err_1cyc", 32'(epb_err), 32'h0);
`else
        tick(1000);
        chk("notmo_rdy", 32'(rdy_cnt - d0), 32'd0);
        chk("notmo_err", 32'(err_cnt - e0), 32'd0);
`endif
        epb_cs_n = 1'b1;
        tick(4);

        // abort during WAIT, late ack ignored
        r0 = req_cnt;
        d0 = rdy_cnt;
        start(23'h000011, 1'b0, 2'b00, 16'h7777);
        wait_req(lat);
        tick(1);
        epb_cs_n = 1'b1;
        tick(1);
        chk("abt_err_pre", 32'(epb_err), 32'h0);
        tick(1);
        chk("abt_err", 32'(epb_err), 32'h1);
        tick(1);
        chk("abt_err_1cyc", 32'(epb_err), 32'h0);
        fab_ack = 1'b1;
        tick(2);
        fab_ack = 1'b0;
        chk("abt_rdy", 32'(rdy_cnt - d0), 32'd0);
        chk("abt_nreq", 32'(req_cnt - r0), 32'd1);
        tick(2);

        // reset during read RESP, cs_n held low across release
        start(23'h000022, 1'b1, 2'b00, 16'h0);
        wait_req(lat);
        fab_ack     = 1'b1;
        fab_rd_data = 16'hCAFE;
        tick(1);
        fab_ack = 1'b0;
        chk("rr_rdy", 32'(epb_rdy), 32'h1);
        chk("rr_oe_n", 32'(epb_data_oe_n), 32'h0);
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk("rr_async_rdy", 32'(epb_rdy), 32'h0);
        chk("rr_async_oe", 32'(epb_data_oe_n), 32'h1);
        tick(1);
        sys_rst_n = 1'b1;
        r0 = req_cnt;
        tick(6);
        chk("rr_noreq", 32'(req_cnt - r0), 32'd0);
        epb_cs_n = 1'b1;
        tick(3);
        start(23'h000033, 1'b1, 2'b00, 16'h0);
        wait_req(lat);
        chk("rr_req_after", 32'(lat), 32'd2);
        chk("rr_addr", 32'(fab_addr), 32'h000033);
        fab_ack = 1'b1;
        tick(1);
        fab_ack = 1'b0;
        epb_cs_n = 1'b1;
        tick(4);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
